// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Round/game flow controller: brick reload, serve delay, play,
//                miss and field-clear handling. Owns lives, score, level and
//                ball speed. Optional macro LEVEL_SPEEDUP_EN makes ball speed
//                follow the level; otherwise ball speed stays at 1.
//  Revision    : 1.0  initial release
// ============================================================================
module game_sequencer #(
   parameter int NUM_BRICKS  = 8,
   parameter int LIVES       = 3,
   parameter int SERVE_DELAY = 60,
   parameter int SCORE_W     = 12,
   parameter int MAX_LEVEL   = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_tick,
   input  logic                  start_btn,
   input  logic                  ball_lost,
   input  logic                  brick_hit,
   input  logic [NUM_BRICKS-1:0] brick_rows,
   output logic                  bricks_reload,
   output logic                  ball_serve,
   output logic                  play_en,
   output logic [1:0]            lives,
   output logic [SCORE_W-1:0]    score,
   output logic [2:0]            level,
   output logic [2:0]            ball_speed,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SERVE = 3'd2,
      S_PLAY  = 3'd3,
      S_MISS  = 3'd4,
      S_CLEAR = 3'd5,
      S_OVER  = 3'd6
   } state_t;

   localparam int c_SUM_W = SCORE_W + 1;

   state_t               r_state;
   logic [7:0]           r_timer;
   logic                 r_start_q;

   logic                 w_start_edge;
   logic [c_SUM_W-1:0]   w_sum;
   logic [SCORE_W-1:0]   w_score_hit;
   logic [2:0]           w_level_next;
   logic [2:0]           w_speed_next;

   always_comb begin
      w_start_edge = start_btn & ~r_start_q;
      // Extra carry bit detects overflow so the score sticks at all-ones.
      w_sum        = {1'b0, score} + c_SUM_W'(level) + c_SUM_W'(1);
      w_score_hit  = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
      w_level_next = (level >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level + 3'd1;
`ifdef LEVEL_SPEEDUP_EN
      w_speed_next = (w_level_next == 3'd7) ? 3'd7 : w_level_next + 3'd1;
`else
      w_speed_next = 3'd1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_timer       <= 8'd0;
         r_start_q     <= 1'b1;
         bricks_reload <= 1'b0;
         ball_serve    <= 1'b0;
         play_en       <= 1'b0;
         lives         <= 2'(LIVES);
         score         <= '0;
         level         <= 3'd0;
         ball_speed    <= 3'd1;
      end else begin
         r_start_q     <= start_btn;
         bricks_reload <= 1'b0;
         ball_serve    <= 1'b0;
         unique case (r_state)
            S_IDLE, S_OVER: begin
               play_en <= 1'b0;
               if (w_start_edge) begin
                  r_state       <= S_LOAD;
                  bricks_reload <= 1'b1;
                  score         <= '0;
                  lives         <= 2'(LIVES);
                  level         <= 3'd0;
                  ball_speed    <= 3'd1;
               end
            end
            S_LOAD: begin
               r_timer <= 8'(SERVE_DELAY);
               r_state <= S_SERVE;
            end
            S_SERVE: begin
               if (frame_tick) begin
                  r_timer <= r_timer - 8'd1;
                  if (r_timer == 8'd1) begin
                     r_state    <= S_PLAY;
                     ball_serve <= 1'b1;
                     play_en    <= 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (brick_hit)
                  score <= w_score_hit;
               // Field clear has priority over a simultaneous ball loss.
               if (brick_rows == '0) begin
                  r_state <= S_CLEAR;
                  play_en <= 1'b0;
               end else if (ball_lost) begin
                  r_state <= S_MISS;
                  play_en <= 1'b0;
               end
            end
            S_MISS: begin
               lives <= lives - 2'd1;
               if (lives == 2'd1) begin
                  r_state <= S_OVER;
               end else begin
                  r_state <= S_SERVE;
                  r_timer <= 8'(SERVE_DELAY);
               end
            end
            S_CLEAR: begin
               level         <= w_level_next;
               ball_speed    <= w_speed_next;
               r_state       <= S_LOAD;
               bricks_reload <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               play_en <= 1'b0;
            end
         endcase
      end
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Directed plus randomized bench for game_sequencer with a
//                cycle-level integer reference model of the game rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_sequencer;

   localparam int NB   = 8;
   localparam int LV   = 3;
   localparam int SD   = 3;
   localparam int SW   = 4;
   localparam int ML   = 7;
   localparam int SMAX = (1 << SW) - 1;

   localparam int ST_IDLE  = 0;
   localparam int ST_LOAD  = 1;
   localparam int ST_SERVE = 2;
   localparam int ST_PLAY  = 3;
   localparam int ST_MISS  = 4;
   localparam int ST_CLEAR = 5;
   localparam int ST_OVER  = 6;

`ifdef LEVEL_SPEEDUP_EN
   localparam int SPEED_L1 = 2;
`else
   localparam int SPEED_L1 = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_tick = 1'b0;
   logic          start_btn = 1'b0;
   logic          ball_lost = 1'b0;
   logic          brick_hit = 1'b0;
   logic [NB-1:0] brick_rows = '1;
   logic          bricks_reload, ball_serve, play_en;
   logic [1:0]    lives;
   logic [SW-1:0] score;
   logic [2:0]    level, ball_speed, state;

   always #5 clk = ~clk;

   game_sequencer #(
      .NUM_BRICKS(NB), .LIVES(LV), .SERVE_DELAY(SD), .SCORE_W(SW), .MAX_LEVEL(ML)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
      .ball_lost(ball_lost), .brick_hit(brick_hit), .brick_rows(brick_rows),
      .bricks_reload(bricks_reload), .ball_serve(ball_serve), .play_en(play_en),
      .lives(lives), .score(score), .level(level), .ball_speed(ball_speed),
      .state(state)
   );

   // Reference model of the game rules, one update per clock edge.
   int m_state = ST_IDLE, m_lives = LV, m_score = 0, m_level = 0, m_speed = 1, m_timer = 0;
   int m_reload = 0, m_serve = 0, m_play = 0, m_start_q = 1;
   int n_pass = 0, n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_step();
      int se;
      se = (start_btn && m_start_q == 0) ? 1 : 0;
      m_start_q = start_btn ? 1 : 0;
      if (rst) begin
         m_state = ST_IDLE; m_lives = LV; m_score = 0; m_level = 0; m_speed = 1;
         m_timer = 0; m_reload = 0; m_serve = 0; m_play = 0; m_start_q = 1;
         return;
      end
      m_reload = 0;
      m_serve  = 0;
      if (m_state == ST_IDLE || m_state == ST_OVER) begin
         if (se == 1) begin
            m_state = ST_LOAD; m_reload = 1;
            m_score = 0; m_lives = LV; m_level = 0; m_speed = 1;
         end
      end else if (m_state == ST_LOAD) begin
         m_state = ST_SERVE; m_timer = SD;
      end else if (m_state == ST_SERVE) begin
         if (frame_tick) begin
            if (m_timer == 1) begin
               m_state = ST_PLAY; m_serve = 1; m_play = 1;
            end
            m_timer = m_timer - 1;
         end
      end else if (m_state == ST_PLAY) begin
         if (brick_hit) m_score = (m_score + m_level + 1 > SMAX) ? SMAX : m_score + m_level + 1;
         if (brick_rows == 0) begin
            m_state = ST_CLEAR; m_play = 0;
         end else if (ball_lost) begin
            m_state = ST_MISS; m_play = 0;
         end
      end else if (m_state == ST_MISS) begin
         m_lives = m_lives - 1;
         if (m_lives == 0) m_state = ST_OVER;
         else begin
            m_state = ST_SERVE; m_timer = SD;
         end
      end else if (m_state == ST_CLEAR) begin
         m_level = (m_level + 1 > ML) ? ML : m_level + 1;
`ifdef LEVEL_SPEEDUP_EN
         m_speed = (m_level + 1 > 7) ? 7 : m_level + 1;
`else
         m_speed = 1;
`endif
         m_state = ST_LOAD; m_reload = 1;
      end
   endtask

   task automatic check_all();
      chk("state",         32'(state),         m_state);
      chk("lives",         32'(lives),         m_lives);
      chk("score",         32'(score),         m_score);
      chk("level",         32'(level),         m_level);
      chk("ball_speed",    32'(ball_speed),    m_speed);
      chk("play_en",       32'(play_en),       m_play);
      chk("ball_serve",    32'(ball_serve),    m_serve);
      chk("bricks_reload", 32'(bricks_reload), m_reload);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // SD frame ticks spaced 10 cycles apart; returns right after the last one.
   task automatic serve_to_play();
      for (int i = 0; i < SD; i++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         if (i < SD - 1) repeat (9) tick();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, 32'(state), ST_IDLE);
      chk({tag, "_lives"}, 32'(lives), LV);
      chk({tag, "_score"}, 32'(score), 0);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_speed"}, 32'(ball_speed), 1);
      chk({tag, "_outs"},  32'({bricks_reload, ball_serve, play_en}), 0);
   endtask

   initial begin
      // Reset with start held: must stay idle after release.
      rst = 1'b1; start_btn = 1'b1;
      repeat (2) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) tick();
      chk("held_start_idle", 32'(state), ST_IDLE);

      start_btn = 1'b0; tick();
      start_btn = 1'b1; tick();
      chk("start_reload", 32'(bricks_reload), 1);
      chk("start_state",  32'(state), ST_LOAD);
      chk("start_lives",  32'(lives), 3);
      chk("start_score",  32'(score), 0);
      start_btn = 1'b0; tick();
      chk("load_to_serve", 32'(state), ST_SERVE);

      serve_to_play();
      chk("serve_pulse", 32'({ball_serve, play_en}), 3);
      chk("serve_state", 32'(state), ST_PLAY);
      tick();
      chk("serve_one_cycle", 32'(ball_serve), 0);

      for (int i = 0; i < 5; i++) begin
         brick_hit = 1'b1; tick();
         brick_hit = 1'b0; tick();
      end
      chk("score_5", 32'(score), 5);
      for (int i = 0; i < 12; i++) begin
         brick_hit = 1'b1; tick();
      end
      brick_hit = 1'b0; tick();
      chk("score_sat", 32'(score), SMAX);

      for (int k = 0; k < 3; k++) begin
         ball_lost = 1'b1; tick();
         ball_lost = 1'b0;
         chk("miss_state", 32'(state), ST_MISS);
         chk("miss_play",  32'(play_en), 0);
         tick();
         chk("miss_lives", 32'(lives), 2 - k);
         if (k < 2) serve_to_play();
      end
      chk("over_state", 32'(state), ST_OVER);
      chk("over_score", 32'(score), SMAX);
      repeat (3) tick();

      start_btn = 1'b1; tick();
      chk("restart_lives", 32'(lives), 3);
      chk("restart_score", 32'(score), 0);
      start_btn = 1'b0; tick();
      serve_to_play();

      brick_rows = '0; ball_lost = 1'b1; tick();
      chk("clear_state", 32'(state), ST_CLEAR);
      chk("clear_lives", 32'(lives), 3);
      brick_rows = '1; ball_lost = 1'b0; tick();
      chk("clear_load",   32'(state), ST_LOAD);
      chk("clear_level",  32'(level), 1);
      chk("clear_reload", 32'(bricks_reload), 1);
      chk("clear_speed",  32'(ball_speed), SPEED_L1);

      tick();
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0;
      chk("serve_mid", 32'(state), ST_SERVE);
      rst = 1'b1; tick();
      check_reset_outputs("midreset");
      rst = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 399) == 0);
         start_btn  = ($urandom_range(0, 7) == 0);
         frame_tick = ($urandom_range(0, 3) == 0);
         brick_hit  = ($urandom_range(0, 2) == 0);
         ball_lost  = ($urandom_range(0, 24) == 0);
         brick_rows = ($urandom_range(0, 39) == 0) ? '0 : NB'($urandom_range(1, 255));
         tick();
      end

      rst = 1'b0; start_btn = 1'b0; frame_tick = 1'b0;
      brick_hit = 1'b0; ball_lost = 1'b0; brick_rows = '1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
